commit_trace_buffer: RTL and testbench

Parametrised retirement-trace buffer that collects per-instruction architectural update records: PC write, up to CSR_CH CSR writes, and one GPR write. It queues them in a DEPTH-entry FIFO and presents them one record per handshake to a downstream consumer, such as a difftest/trace bridge. Records that change no state are filtered out, and the block keeps retire/skip statistics. It sits between the writeback stage and the simulation-side reference-model bridge, decoupling commit rate from consumer rate.

---
 rtl/commit_trace_buffer.sv | 150 +++++++++++++++
 tb/tb_commit_trace_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: retirement-trace FIFO between writeback and a trace/difftest
// consumer. Records that change no architectural state are dropped and counted as
// skipped; all others are queued verbatim (with x0 writes masked) and handed out one
// per out_valid/out_ready handshake.
module commit_trace_buffer #(
    parameter int XLEN   = 32,
    parameter int CSR_CH = 2,
    parameter int CSR_AW = 12,
    parameter int GPR_AW = 5,
    parameter int DEPTH  = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_pc_wen,
    input  logic [CSR_CH-1:0]          in_csr_wen,
    input  logic                       in_gpr_wen,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [CSR_CH*CSR_AW-1:0]   in_csr_waddr,
    input  logic [CSR_CH*XLEN-1:0]     in_csr_wdata,
    input  logic [GPR_AW-1:0]          in_gpr_waddr,
    input  logic [XLEN-1:0]            in_gpr_wdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_pc_wen,
    output logic [CSR_CH-1:0]          out_csr_wen,
    output logic                       out_gpr_wen,
    output logic [XLEN-1:0]            out_pc,
    output logic [CSR_CH*CSR_AW-1:0]   out_csr_waddr,
    output logic [CSR_CH*XLEN-1:0]     out_csr_wdata,
    output logic [GPR_AW-1:0]          out_gpr_waddr,
    output logic [XLEN-1:0]            out_gpr_wdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic [31:0]                retire_cnt,
    output logic [31:0]                skip_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   retire_cnt_q, retire_cnt_d;
    logic [31:0]   skip_cnt_q, skip_cnt_d;

    // Record storage; contents are only observable while non-empty, so no reset.
    logic                     pc_wen_mem_q    [DEPTH];
    logic [CSR_CH-1:0]        csr_wen_mem_q   [DEPTH];
    logic                     gpr_wen_mem_q   [DEPTH];
    logic [XLEN-1:0]          pc_mem_q        [DEPTH];
    logic [CSR_CH*CSR_AW-1:0] csr_waddr_mem_q [DEPTH];
    logic [CSR_CH*XLEN-1:0]   csr_wdata_mem_q [DEPTH];
    logic [GPR_AW-1:0]        gpr_waddr_mem_q [DEPTH];
    logic [XLEN-1:0]          gpr_wdata_mem_q [DEPTH];

    logic full_s, empty_s, gpr_wen_eff_s, useful_s, accept_s, enq_s, skip_s, deq_s;

    // Queue status, input filtering and next-state computation.
    always_comb begin
        full_s        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        empty_s       = (wr_ptr_q == rd_ptr_q);
        gpr_wen_eff_s = in_gpr_wen && (in_gpr_waddr != {GPR_AW{1'b0}});
        useful_s      = in_pc_wen || (|in_csr_wen) || gpr_wen_eff_s;
        accept_s      = in_valid && !full_s;
        enq_s         = accept_s && useful_s && !flush;
        skip_s        = accept_s && !useful_s && !flush;
        deq_s         = !empty_s && out_ready && !flush;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        retire_cnt_d  = retire_cnt_q + {31'd0, enq_s};
        skip_cnt_d    = skip_cnt_q + {31'd0, skip_s};
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Pointer and statistics state, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            retire_cnt_q <= 32'd0;
            skip_cnt_q   <= 32'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            retire_cnt_q <= retire_cnt_d;
            skip_cnt_q   <= skip_cnt_d;
        end
    end

    // Write a storable record at the write pointer, with x0 writes masked.
    always_ff @(posedge clock) begin
        if (enq_s) begin
            pc_wen_mem_q[wr_ptr_q[AW-1:0]]    <= in_pc_wen;
            csr_wen_mem_q[wr_ptr_q[AW-1:0]]   <= in_csr_wen;
            gpr_wen_mem_q[wr_ptr_q[AW-1:0]]   <= gpr_wen_eff_s;
            pc_mem_q[wr_ptr_q[AW-1:0]]        <= in_pc;
            csr_waddr_mem_q[wr_ptr_q[AW-1:0]] <= in_csr_waddr;
            csr_wdata_mem_q[wr_ptr_q[AW-1:0]] <= in_csr_wdata;
            gpr_waddr_mem_q[wr_ptr_q[AW-1:0]] <= in_gpr_waddr;
            gpr_wdata_mem_q[wr_ptr_q[AW-1:0]] <= in_gpr_wdata;
        end
    end

    // Present the head record; fields read as zero while the queue is empty.
    always_comb begin
        in_ready   = !full_s;
        out_valid  = !empty_s;
        level      = wr_ptr_q - rd_ptr_q;
        retire_cnt = retire_cnt_q;
        skip_cnt   = skip_cnt_q;
        if (empty_s) begin
            out_pc_wen    = 1'b0;
            out_csr_wen   = {CSR_CH{1'b0}};
            out_gpr_wen   = 1'b0;
            out_pc        = {XLEN{1'b0}};
            out_csr_waddr = {(CSR_CH*CSR_AW){1'b0}};
            out_csr_wdata = {(CSR_CH*XLEN){1'b0}};
            out_gpr_waddr = {GPR_AW{1'b0}};
            out_gpr_wdata = {XLEN{1'b0}};
        end else begin
            out_pc_wen    = pc_wen_mem_q[rd_ptr_q[AW-1:0]];
            out_csr_wen   = csr_wen_mem_q[rd_ptr_q[AW-1:0]];
            out_gpr_wen   = gpr_wen_mem_q[rd_ptr_q[AW-1:0]];
            out_pc        = pc_mem_q[rd_ptr_q[AW-1:0]];
            out_csr_waddr = csr_waddr_mem_q[rd_ptr_q[AW-1:0]];
            out_csr_wdata = csr_wdata_mem_q[rd_ptr_q[AW-1:0]];
            out_gpr_waddr = gpr_waddr_mem_q[rd_ptr_q[AW-1:0]];
            out_gpr_wdata = gpr_wdata_mem_q[rd_ptr_q[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: stimulus pushes expected records,
// a negedge monitor pops and compares on every out_valid && out_ready.
module tb_commit_trace_buffer;

    typedef struct packed {
        logic        pc_wen;
        logic [1:0]  csr_wen;
        logic        gpr_wen;
        logic [31:0] pc;
        logic [23:0] csr_waddr;
        logic [63:0] csr_wdata;
        logic [4:0]  gpr_waddr;
        logic [31:0] gpr_wdata;
    } rec_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_pc_wen = 1'b0;
    logic [1:0]  in_csr_wen = 2'b00;
    logic        in_gpr_wen = 1'b0;
    logic [31:0] in_pc = 32'd0;
    logic [23:0] in_csr_waddr = 24'd0;
    logic [63:0] in_csr_wdata = 64'd0;
    logic [4:0]  in_gpr_waddr = 5'd0;
    logic [31:0] in_gpr_wdata = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_pc_wen;
    logic [1:0]  out_csr_wen;
    logic        out_gpr_wen;
    logic [31:0] out_pc;
    logic [23:0] out_csr_waddr;
    logic [63:0] out_csr_wdata;
    logic [4:0]  out_gpr_waddr;
    logic [31:0] out_gpr_wdata;
    logic [3:0]  level;
    logic [31:0] retire_cnt;
    logic [31:0] skip_cnt;

    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_retire = 0;
    int   exp_skip = 0;
    rec_t sb_q[$];

    commit_trace_buffer dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc_wen(in_pc_wen), .in_csr_wen(in_csr_wen), .in_gpr_wen(in_gpr_wen),
        .in_pc(in_pc), .in_csr_waddr(in_csr_waddr), .in_csr_wdata(in_csr_wdata),
        .in_gpr_waddr(in_gpr_waddr), .in_gpr_wdata(in_gpr_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc_wen(out_pc_wen), .out_csr_wen(out_csr_wen), .out_gpr_wen(out_gpr_wen),
        .out_pc(out_pc), .out_csr_waddr(out_csr_waddr), .out_csr_wdata(out_csr_wdata),
        .out_gpr_waddr(out_gpr_waddr), .out_gpr_wdata(out_gpr_wdata),
        .level(level), .retire_cnt(retire_cnt), .skip_cnt(skip_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic rec_t mk_pc(logic [31:0] pc);
        rec_t r;
        r = '0;
        r.pc_wen    = 1'b1;
        r.pc        = pc;
        r.gpr_wdata = ~pc;
        return r;
    endfunction

    task automatic set_in(rec_t r);
        in_pc_wen    = r.pc_wen;
        in_csr_wen   = r.csr_wen;
        in_gpr_wen   = r.gpr_wen;
        in_pc        = r.pc;
        in_csr_waddr = r.csr_waddr;
        in_csr_wdata = r.csr_wdata;
        in_gpr_waddr = r.gpr_waddr;
        in_gpr_wdata = r.gpr_wdata;
    endtask

    // Offer one record and wait (bounded) for it to be accepted; called at posedge+1.
    task automatic send(rec_t r, bit store);
        bit rdy;
        bit done;
        done = 1'b0;
        set_in(r);
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clock);
            rdy = in_ready;
            @(posedge clock);
            #1;
            done = rdy;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_timeout: actual=not_accepted required=accepted pc=%0h", r.pc);
        end else if (store) begin
            sb_q.push_back(r);
            exp_retire++;
        end else begin
            exp_skip++;
        end
    endtask

    // Monitor: compare every handshaked head record against the scoreboard.
    always @(negedge clock) begin
        rec_t got;
        if (reset_n && out_valid && out_ready) begin
            got = {out_pc_wen, out_csr_wen, out_gpr_wen, out_pc, out_csr_waddr,
                   out_csr_wdata, out_gpr_waddr, out_gpr_wdata};
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pop: actual pc=%0h required=no_record", out_pc);
            end else begin
                rec_t e;
                e = sb_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL record: actual=%0h required=%0h", got, e);
                end
            end
        end
    end

    initial begin
        rec_t r;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_level", 64'(level), 64'd0);
        check("rst_retire", 64'(retire_cnt), 64'd0);
        check("rst_skip", 64'(skip_cnt), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_out_gpr_wdata", 64'(out_gpr_wdata), 64'd0);

        // Single record, pass-through with out_ready=1
        out_ready = 1'b1;
        r = mk_pc(32'h8000_0004);
        r.gpr_wen = 1'b1; r.gpr_waddr = 5'd5; r.gpr_wdata = 32'hDEAD_BEEF;
        send(r, 1'b1);
        check("single_out_valid", 64'(out_valid), 64'd1);
        check("single_out_pc", 64'(out_pc), 64'h8000_0004);
        check("single_retire", 64'(retire_cnt), 64'd1);
        @(posedge clock); #1;
        check("single_level_after_pop", 64'(level), 64'd0);

        // x0-only write is filtered
        r = '0; r.gpr_wen = 1'b1; r.gpr_waddr = 5'd0; r.gpr_wdata = 32'h5555_AAAA;
        send(r, 1'b0);
        check("skip_skip_cnt", 64'(skip_cnt), 64'd1);
        check("skip_retire_cnt", 64'(retire_cnt), 64'd1);
        check("skip_out_valid", 64'(out_valid), 64'd0);
        check("skip_level", 64'(level), 64'd0);

        // Fill to DEPTH, hold a 9th, then drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(mk_pc(32'(i * 4)), 1'b1);
        check("full_level", 64'(level), 64'd8);
        check("full_in_ready", 64'(in_ready), 64'd0);
        set_in(mk_pc(32'h20));
        in_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("full_hold_level", 64'(level), 64'd8);
        check("full_hold_retire", 64'(retire_cnt), 64'd9);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        check("drain_level", 64'(level), 64'd0);
        check("drain_out_valid", 64'(out_valid), 64'd0);
        check("drain_sb_empty", 64'(sb_q.size()), 64'd0);

        // Steady state at level 3 across pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(mk_pc(32'h100 + 32'(i * 4)), 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(mk_pc(32'h200 + 32'(i * 4)), 1'b1);
            check("steady_level", 64'(level), 64'd3);
        end
        repeat (3) @(posedge clock);
        #1;
        check("steady_drain_level", 64'(level), 64'd0);

        // CSR channel 1 only
        out_ready = 1'b0;
        r = '0; r.csr_wen = 2'b10; r.csr_waddr = 24'h341_000; r.csr_wdata = 64'h0000_1234_0000_0000;
        send(r, 1'b1);
        check("csr_out_csr_wen", 64'(out_csr_wen), 64'h2);
        check("csr_ch1_addr", 64'(out_csr_waddr[23:12]), 64'h341);
        check("csr_ch1_data", 64'(out_csr_wdata[63:32]), 64'h1234);
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("csr_level_after_pop", 64'(level), 64'd0);

        // Flush at level 5 with a simultaneous offer
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(mk_pc(32'h300 + 32'(i * 4)), 1'b1);
        check("pre_flush_level", 64'(level), 64'd5);
        set_in(mk_pc(32'h400));
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        sb_q.delete();
        check("flush_level", 64'(level), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_retire", 64'(retire_cnt), 64'(exp_retire));
        check("flush_skip", 64'(skip_cnt), 64'(exp_skip));

        // Mid-queue reset pulse
        for (int i = 0; i < 2; i++) send(mk_pc(32'h500 + 32'(i * 4)), 1'b1);
        reset_n = 1'b0;
        #1;
        check("areset_out_valid", 64'(out_valid), 64'd0);
        check("areset_level", 64'(level), 64'd0);
        check("areset_in_ready", 64'(in_ready), 64'd1);
        check("areset_retire", 64'(retire_cnt), 64'd0);
        check("areset_skip", 64'(skip_cnt), 64'd0);
        check("areset_out_pc", 64'(out_pc), 64'd0);
        sb_q.delete();
        exp_retire = 0;
        exp_skip = 0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        send(mk_pc(32'h600), 1'b1);
        check("post_reset_retire", 64'(retire_cnt), 64'd1);
        @(posedge clock); #1;
        check("final_level", 64'(level), 64'd0);
        check("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
